// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, with
//           valid/ready handshakes on the operand and result sides.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             br;
  logic             bout_r;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             diff_bit;
  logic             br_nxt;
  logic             last_bit;

  // Full-subtractor cell applied to the current LSB pair
  assign x        = a_sh[0];
  assign y        = b_sh[0];
  assign diff_bit = x ^ y ^ br;
  assign br_nxt   = (~x & y) | (~x & br) | (y & br);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are pure state decodes, no path from in_valid/out_ready
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      br      <= 1'b0;
      bout_r  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          diff_sh <= {diff_bit, diff_sh[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          br      <= br_nxt;
          cnt     <= cnt + CW'(1);
          if (last_bit) bout_r <= br_nxt;
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_sh;
  assign bout = bout_r;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Brief   : Directed and randomized checks of serial_subtractor against a
//           transaction-level arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Transaction model: phase 0 idle, 1 computing, 2 result held
  int               m_phase = 0;
  int               m_rem   = 0;
  int               m_acc   = 0;
  int               m_drop  = 0;
  int               dut_hs  = 0;
  logic [WIDTH:0]   m_res   = '0;
  logic [WIDTH:0]   m_last  = '0;
  bit               chk_en  = 1'b0;
  logic [2:0]       exp_ctl;

  always @(posedge clk) begin
    if (rst) begin
      if (m_phase != 0) m_drop++;
      m_phase = 0;
      m_last  = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_res   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
          m_rem   = WIDTH;
          m_phase = 1;
          m_acc++;
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 2;
            m_last  = m_res;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_ctl = {m_phase == 0, m_phase == 1, m_phase == 2};
      check("ctl", 64'({in_ready, busy, out_valid}), 64'(exp_ctl));
      if (m_phase != 1) check("result", 64'({bout, diff}), 64'(m_last));
      if (out_valid && out_ready) dut_hs++;
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ibin, input logic [WIDTH-1:0] ed, input logic eb,
                        input int stall, input bit hold_next);
    int n;
    int lat;
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) begin
      check("accept_timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    check("latency", 64'(lat), 64'(WIDTH));
    check("diff", 64'(diff), 64'(ed));
    check("bout", 64'(bout), 64'(eb));
    if (hold_next) begin
      a = 8'h22; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    end
    repeat (stall) begin
      tick();
      check("stall_stable", 64'({in_ready, out_valid, bout, diff}), 64'({1'b0, 1'b1, eb, ed}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int cyc;
    int n;
    bit accepting;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) tick();
    check("reset_state", 64'({in_ready, out_valid, busy, bout, diff}), 64'({3'b100, 1'b0, 8'h00}));
    rst = 1'b0;
    chk_en = 1'b1;

    // Hand-computed results pin both the DUT and the model
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0, 1'b0);

    // Backpressure with a second request waiting during the stall
    run_op(8'h40, 8'h41, 1'b0, 8'hFF, 1'b1, 5, 1'b1);
    run_op(8'h22, 8'h11, 1'b0, 8'h11, 1'b0, 0, 1'b0);

    // Reset while bit 3 is being processed
    a = 8'h5A; b = 8'h33; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset", 64'({in_ready, out_valid, bout, diff}), 64'({2'b10, 1'b0, 8'h00}));
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0, 1'b0);

    // Random traffic; operands only change after acceptance
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 60000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      accepting = in_valid && in_ready;
      tick();
      cyc++;
      if (accepting) begin
        acc++;
        in_valid = 1'b0;
      end
    end
    check("random_accepts", 64'(acc), 64'(1000));

    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (m_phase != 0 && n < 100) begin tick(); n++; end
    tick();
    check("handshakes", 64'(dut_hs), 64'(m_acc - m_drop));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
